// File: rtl/difftest_log_pkg.sv
// Shared types for the per-event performance-counter logger.
// The record layout is fixed here so the FIFO, the interface and the top all agree on it.
package difftest_log_pkg;

  localparam int WIN_W      = 16;
  localparam int DROP_W     = 16;
  localparam int LOG_CNT_W  = 32;
  localparam int LOG_CORE_W = 8;

  typedef struct packed {
    logic [LOG_CORE_W-1:0] core;
    logic [WIN_W-1:0]      win;
    logic [LOG_CNT_W-1:0]  delta;
    logic [LOG_CNT_W-1:0]  total;
    logic [LOG_CNT_W-1:0]  peak;
    logic                  is_final;
  } log_rec_t;

  function automatic logic [LOG_CNT_W-1:0] cnt_max(input logic [LOG_CNT_W-1:0] a,
                                                    input logic [LOG_CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/difftest_log_if.sv
// Valid/ready record channel from an event logger to the shared difftest collector.
interface difftest_log_if import difftest_log_pkg::*; ;

  logic                  log_valid;
  logic                  log_ready;
  logic [LOG_CORE_W-1:0] log_core;
  logic [WIN_W-1:0]      log_win;
  logic [LOG_CNT_W-1:0]  log_delta;
  logic [LOG_CNT_W-1:0]  log_total;
  logic [LOG_CNT_W-1:0]  log_peak;
  logic                  log_final;

  modport master (
    output log_valid, log_core, log_win, log_delta, log_total, log_peak, log_final,
    input  log_ready
  );

  modport slave (
    input  log_valid, log_core, log_win, log_delta, log_total, log_peak, log_final,
    output log_ready
  );

endinterface

// File: rtl/difftest_log_fifo.sv
// DEPTH x log_rec_t FIFO (DEPTH a power of two, >= 2); head reads as zero when empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module difftest_log_fifo import difftest_log_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_push,
  input  log_rec_t i_rec,
  input  logic     i_pop,
  output log_rec_t o_head,
  output logic     o_full,
  output logic     o_empty
);

  localparam int AW = $clog2(DEPTH);

  log_rec_t        r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_wr_en;
  logic            w_rd_en;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_rd_en = i_pop && !o_empty;
  assign w_wr_en = i_push && (!o_full || w_rd_en);
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage carries no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_rec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_wr_en) - (AW+1)'(w_rd_en);
    end
  end

endmodule

// File: rtl/difftest_log_event.sv
// Per-event perf-counter logger: closes a window every WINDOW cycles or on dump_req,
// and queues one {core, win, delta, total, peak, final} record per window for the collector.
module difftest_log_event import difftest_log_pkg::*; #(
  parameter     NAME   = "event",
  parameter int CNT_W  = LOG_CNT_W,
  parameter int CORE_W = LOG_CORE_W,
  parameter int WINDOW = 1024,
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CORE_W-1:0] i_coreid,
  input  logic [CNT_W-1:0]  i_value,
  input  logic              i_dump_req,
  difftest_log_if.master    log_bus,
  output logic [DROP_W-1:0] o_drop_cnt
);

  localparam int CYC_W = $clog2(WINDOW);

  if (CNT_W != LOG_CNT_W || CORE_W != LOG_CORE_W) begin : g_bad_width
    $error("CNT_W/CORE_W must match the widths of log_rec_t");
  end
  if (WINDOW < 4 || (WINDOW & (WINDOW - 1)) != 0) begin : g_bad_window
    $error("WINDOW must be a power of two >= 4");
  end
  if ($bits(NAME) < 8) begin : g_bad_name
    $error("NAME must not be empty");
  end

  logic [CYC_W-1:0]  r_cyc;
  logic [CNT_W-1:0]  r_snap;
  logic [CNT_W-1:0]  r_peak;
  logic [WIN_W-1:0]  r_win;
  logic [DROP_W-1:0] r_drop;

  logic              w_close;
  logic [CNT_W-1:0]  w_delta;
  logic [CNT_W-1:0]  w_peak_new;
  log_rec_t          w_rec;
  log_rec_t          w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;

  // Unsigned subtraction gives the right delta across counter wrap.
  assign w_close    = (r_cyc == CYC_W'(WINDOW - 1)) || i_dump_req;
  assign w_delta    = i_value - r_snap;
  assign w_peak_new = cnt_max(r_peak, w_delta);
  assign w_pop      = !w_empty && log_bus.log_ready;
  assign w_rec      = '{core: i_coreid, win: r_win, delta: w_delta, total: i_value,
                        peak: w_peak_new, is_final: i_dump_req};

  difftest_log_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_close),
    .i_rec   (w_rec),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc  <= '0;
      r_snap <= '0;
      r_peak <= '0;
      r_win  <= '0;
      r_drop <= '0;
    end else begin
      r_cyc <= w_close ? '0 : r_cyc + CYC_W'(1);
      if (w_close) begin
        r_snap <= i_value;
        r_peak <= w_peak_new;
        if (r_win != '1) r_win <= r_win + WIN_W'(1);
        if (w_full && !w_pop && r_drop != '1) r_drop <= r_drop + DROP_W'(1);
      end
    end
  end

  assign log_bus.log_valid = !w_empty;
  assign log_bus.log_core  = w_head.core;
  assign log_bus.log_win   = w_head.win;
  assign log_bus.log_delta = w_head.delta;
  assign log_bus.log_total = w_head.total;
  assign log_bus.log_peak  = w_head.peak;
  assign log_bus.log_final = w_head.is_final;
  assign o_drop_cnt        = r_drop;

`ifdef DIFFTEST
  always_ff @(posedge clk) begin
    if (!rst && w_pop) begin
      $display("[%s] core=%d win=%d delta=%d total=%d",
               NAME, w_head.core, w_head.win, w_head.delta, w_head.total);
    end
  end
`endif

endmodule

// File: tb/tb_difftest_log_event.sv
// Directed bench for difftest_log_event: a queue-based record model is compared every cycle,
// and each scenario pins hand-computed record values captured at the collector side.
module tb_difftest_log_event;
  import difftest_log_pkg::*;

  localparam int WINDOW = 8;
  localparam int QDEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  coreid;
  logic [31:0] value;
  logic        dump_req;
  logic [15:0] drop_cnt;

  difftest_log_if u_if();

  difftest_log_event #(
    .NAME   ("perf"),
    .WINDOW (WINDOW),
    .QDEPTH (QDEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_coreid   (coreid),
    .i_value    (value),
    .i_dump_req (dump_req),
    .log_bus    (u_if),
    .o_drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: records waiting for the collector, plus what the logger must remember between windows.
  log_rec_t    m_q[$];
  logic [31:0] m_snap;
  logic [31:0] m_peak;
  logic [15:0] m_win;
  logic [15:0] m_drop;
  int          m_since;

  always @(posedge clk or posedge rst) begin
    logic [31:0] d;
    log_rec_t    rec;
    if (rst) begin
      m_q.delete();
      m_snap  = 0;
      m_peak  = 0;
      m_win   = 0;
      m_drop  = 0;
      m_since = 0;
    end else begin
      if (m_q.size() > 0 && u_if.log_ready) rec = m_q.pop_front();
      if (m_since == WINDOW - 1 || dump_req) begin
        d = value - m_snap;
        if (d > m_peak) m_peak = d;
        rec = '{core: coreid, win: m_win, delta: d, total: value, peak: m_peak, is_final: dump_req};
        if (m_q.size() < QDEPTH) m_q.push_back(rec);
        else if (m_drop != 16'hFFFF) m_drop++;
        m_snap = value;
        if (m_win != 16'hFFFF) m_win++;
        m_since = 0;
      end else begin
        m_since++;
      end
    end
  end

  // Records accepted by the collector, as seen on the DUT outputs.
  log_rec_t got[$];

  always @(negedge clk) begin
    log_rec_t e;
    e = '0;
    if (m_q.size() > 0) e = m_q[0];
    check("log_valid", u_if.log_valid, m_q.size() > 0);
    check("log_core",  u_if.log_core,  e.core);
    check("log_win",   u_if.log_win,   e.win);
    check("log_delta", u_if.log_delta, e.delta);
    check("log_total", u_if.log_total, e.total);
    check("log_peak",  u_if.log_peak,  e.peak);
    check("log_final", u_if.log_final, e.is_final);
    check("drop_cnt",  drop_cnt,       m_drop);
    if (u_if.log_valid && u_if.log_ready) begin
      got.push_back('{core: u_if.log_core, win: u_if.log_win, delta: u_if.log_delta,
                      total: u_if.log_total, peak: u_if.log_peak, is_final: u_if.log_final});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dump_req = 1'b0;
    value = 0;
    u_if.log_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    got.delete();
  endtask

  initial begin
    rst = 1'b1;
    value = 0;
    dump_req = 1'b0;
    coreid = 8'h5A;
    u_if.log_ready = 1'b1;
    #1;
    check("reset valid", u_if.log_valid, 0);
    check("reset drop",  drop_cnt, 0);

    // Natural windows: value rises by 1 per cycle, so every window counts 8.
    do_reset();
    for (int i = 0; i < 24; i++) begin
      value = i + 1;
      tick();
    end
    value = 25; tick();
    value = 26; tick();
    check("timing count", got.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) begin
        check("timing win",   got[i].win,      i);
        check("timing delta", got[i].delta,    8);
        check("timing total", got[i].total,    8 * (i + 1));
        check("timing final", got[i].is_final, 0);
      end
    end

    // Counter wrap between two dump-closed windows.
    do_reset();
    value = 32'hFFFF_FFF0; dump_req = 1'b1; tick();
    dump_req = 1'b0; tick();
    value = 32'h0000_0010; dump_req = 1'b1; tick();
    dump_req = 1'b0; tick(); tick();
    check("wrap count", got.size(), 2);
    if (got.size() > 1) begin
      check("wrap delta", got[1].delta,    32'h20);
      check("wrap total", got[1].total,    32'h10);
      check("wrap peak",  got[1].peak,     32'hFFFF_FFF0);
      check("wrap final", got[1].is_final, 1);
    end

    // Early dump at cycle counter 3, then a full window restarting from 0.
    do_reset();
    value = 0; tick();
    value = 1; tick();
    value = 2; tick();
    value = 3; dump_req = 1'b1; tick();
    dump_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      value = 4 + i;
      tick();
    end
    tick(); tick();
    check("dump count", got.size(), 2);
    if (got.size() > 1) begin
      check("dump delta", got[0].delta,    3);
      check("dump final", got[0].is_final, 1);
      check("next win",   got[1].win,      1);
      check("next delta", got[1].delta,    8);
      check("next total", got[1].total,    11);
      check("next final", got[1].is_final, 0);
    end

    // Backpressure for four windows with a two-entry queue.
    do_reset();
    u_if.log_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      value = i + 1;
      tick();
    end
    check("bp valid", u_if.log_valid, 1);
    check("bp head win", u_if.log_win, 0);
    check("bp head total", u_if.log_total, 8);
    check("bp drop", drop_cnt, 2);
    u_if.log_ready = 1'b1;
    value = 33; tick();
    value = 34; tick();
    value = 35; tick();
    check("bp drain count", got.size(), 2);
    if (got.size() > 1) begin
      check("bp drain win0",   got[0].win,   0);
      check("bp drain win1",   got[1].win,   1);
      check("bp drain total1", got[1].total, 16);
    end

    // Peak tracking over deltas 5, 9, 3.
    do_reset();
    coreid = 8'h3C;
    value = 0; tick();
    value = 5;  dump_req = 1'b1; tick();
    value = 14; tick();
    value = 17; tick();
    dump_req = 1'b0; tick(); tick();
    check("peak count", got.size(), 3);
    if (got.size() > 2) begin
      check("peak 0", got[0].peak, 5);
      check("peak 1", got[1].peak, 9);
      check("peak 2", got[2].peak, 9);
      check("peak delta 2", got[2].delta, 3);
      check("peak core", got[2].core, 8'h3C);
    end

    // dump_req coinciding with the natural close gives a single final record.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      value = i;
      dump_req = (i == 7);
      tick();
    end
    dump_req = 1'b0;
    tick(); tick();
    check("coincide count", got.size(), 2);
    if (got.size() > 1) begin
      check("coincide final", got[0].is_final, 1);
      check("coincide delta", got[0].delta,    7);
      check("coincide win1",  got[1].win,      1);
    end

    // Asynchronous reset while a record is pending.
    do_reset();
    u_if.log_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      value = i + 1;
      tick();
    end
    check("pre-rst valid", u_if.log_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst valid", u_if.log_valid, 0);
    check("async rst win",   u_if.log_win,   0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    got.delete();
    u_if.log_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      value = 100 + i;
      tick();
    end
    check("post-rst count", got.size(), 1);
    if (got.size() > 0) begin
      check("post-rst win",   got[0].win,   0);
      check("post-rst delta", got[0].delta, 107);
    end
    check("post-rst drop", drop_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
